// File: rtl/serial_subtractor_4.sv
// Bit-serial subtractor: recovers a = {cout,s} - b one bit per clock, LSB first, registered borrow.
// Latency: done pulses WIDTH+1 cycles after the accepting start edge; results hold until the next done.
// Backpressure: none; start is only sampled in IDLE/DONE, ignored while busy, and accepted back-to-back in DONE.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset; aborts any operation in flight
//   start   request; accepted in IDLE or DONE, captures {cout,s} and b
//   s/cout  minuend {cout,s} (WIDTH+1 bits)
//   b       subtrahend (WIDTH bits, zero-extended)
//   busy    high while bits are being processed
//   done    one-cycle pulse, d/borrow/ovf valid alongside it
//   d       low WIDTH bits of the difference (two's complement when negative)
//   borrow  final borrow, i.e. {cout,s} < b
//   ovf     nonnegative result that does not fit in WIDTH bits

module serial_subtractor_4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] s,
  input  logic             cout,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             borrow,
  output logic             ovf
);

  // Counter must reach WIDTH (index of the final step).
  localparam int CW = (WIDTH < 1) ? 1 : $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   m_q, m_d;      // minuend shift register
  logic [WIDTH:0]   b_q, b_d;      // subtrahend shift register
  logic [WIDTH:0]   r_q, r_d;      // result shift register, fills from the top
  logic             br_q, br_d;    // running borrow
  logic [CW-1:0]    cnt_q, cnt_d;  // steps already taken
  logic [WIDTH-1:0] d_q, d_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;

  logic step_bit;
  logic step_br;
  logic last_step;

  // One full-subtractor slice on the current LSBs.
  always_comb begin
    step_bit  = m_q[0] ^ b_q[0] ^ br_q;
    step_br   = (~m_q[0] & b_q[0]) | (~(m_q[0] ^ b_q[0]) & br_q);
    last_step = (cnt_q == CW'(WIDTH));
  end

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    b_d      = b_q;
    r_d      = r_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    d_d      = d_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Operand capture; previous results stay visible until the next done.
          state_d = RUN;
          m_d     = {cout, s};
          b_d     = {1'b0, b};
          br_d    = 1'b0;
          cnt_d   = '0;
          r_d     = '0;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        m_d   = m_q >> 1;
        b_d   = b_q >> 1;
        br_d  = step_br;
        r_d   = (r_q >> 1) | {step_bit, {WIDTH{1'b0}}};
        cnt_d = cnt_q + CW'(1);
        if (last_step) begin
          // Publish on the same edge as the final step so outputs align with done.
          state_d  = DONE;
          d_d      = r_d[WIDTH-1:0];
          borrow_d = step_br;
          ovf_d    = step_bit & ~step_br;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      m_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      d_q      <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      b_q      <= b_d;
      r_q      <= r_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      d_q      <= d_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign d      = d_q;
  assign borrow = borrow_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_subtractor_4.sv
module tb_serial_subtractor_4;

  localparam int W = 4;

  typedef logic [W:0] res_t;
  typedef struct {
    logic [W-1:0] d;
    logic         br;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cout = 1'b0;
  logic [W-1:0] s = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, borrow, ovf;
  logic [W-1:0] d;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic [W-1:0] last_d   = '0;
  logic         last_br  = 1'b0;
  logic         last_ovf = 1'b0;

  serial_subtractor_4 #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .s      (s),
    .cout   (cout),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .d      (d),
    .borrow (borrow),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic c, input logic [W-1:0] ss, input logic [W-1:0] bb);
    exp_t e;
    int   mv;
    int   bv;
    res_t rr;
    mv    = int'({c, ss});
    bv    = int'(bb);
    rr    = res_t'(mv - bv);
    e.br  = (mv < bv);
    e.d   = rr[W-1:0];
    e.ovf = rr[W] & ~e.br;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is seen by the following rising edge.
  task automatic do_start(input logic c, input logic [W-1:0] ss, input logic [W-1:0] bb);
    cout  = c;
    s     = ss;
    b     = bb;
    start = 1'b1;
    sb.push_back(model(c, ss, bb));
    @(posedge clk);
    #1;
    start = 1'b0;
    cout  = 1'($urandom);
    s     = W'($urandom);
    b     = W'($urandom);
  endtask

  // Waits for done with a bounded cycle budget; optionally injects a start mid-run.
  task automatic wait_done(input string tag, input bit inject);
    int   cyc = 0;
    int   busy_cnt = 0;
    bit   seen = 1'b0;
    exp_t e;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check({tag, "_hold_d"}, 32'(d), 32'(last_d));
        check({tag, "_hold_br"}, 32'(borrow), 32'(last_br));
      end
      if (inject && cyc == 2) begin
        start = 1'b1;
        cout  = 1'($urandom);
        s     = W'($urandom);
        b     = W'($urandom);
      end
      if (inject && cyc == 3) start = 1'b0;
      if (done) seen = 1'b1;
      else if (busy) busy_cnt++;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(W + 1));
    check({tag, "_latency"}, 32'(cyc), 32'(W + 2));
    if (seen) begin
      check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      if (sb.size() == 0) begin
        check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        check({tag, "_d"}, 32'(d), 32'(e.d));
        check({tag, "_borrow"}, 32'(borrow), 32'(e.br));
        check({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
        last_d   = e.d;
        last_br  = e.br;
        last_ovf = e.ovf;
      end
    end
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, "_done_low"}, 32'(done), 32'd0);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_d_hold"}, 32'(d), 32'(last_d));
    check({tag, "_ovf_hold"}, 32'(ovf), 32'(last_ovf));
  endtask

  initial begin
    int done_cnt;
    int busy_cnt;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_outs", 32'({busy, done, d, borrow, ovf}), 32'd0);

    // Valid-sum inversion
    do_start(1'b1, 4'b1110, 4'b1111);
    wait_done("inv1", 1'b0);
    idle_check("inv1");
    do_start(1'b0, 4'b0000, 4'b0000);
    wait_done("inv2", 1'b0);
    idle_check("inv2");

    // Negative result and overflow
    do_start(1'b0, 4'b0001, 4'b0010);
    wait_done("neg", 1'b0);
    idle_check("neg");
    do_start(1'b1, 4'b0000, 4'b0000);
    wait_done("ovf", 1'b0);
    idle_check("ovf");

    // Start during RUN is ignored
    do_start(1'b0, 4'b1001, 4'b0011);
    wait_done("inrun", 1'b1);
    idle_check("inrun_a");
    idle_check("inrun_b");

    // Back-to-back: start asserted in the DONE cycle
    do_start(1'b1, 4'b0101, 4'b0010);
    wait_done("b2b_a", 1'b0);
    do_start(1'b0, 4'b0111, 4'b0011);
    wait_done("b2b_b", 1'b0);
    idle_check("b2b_b");

    // Reset mid-operation
    do_start(1'b0, 4'b1100, 4'b0001);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_d", 32'(d), 32'd0);
    check("arst_borrow", 32'(borrow), 32'd0);
    check("arst_ovf", 32'(ovf), 32'd0);
    sb.delete();
    last_d   = '0;
    last_br  = 1'b0;
    last_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
    check("arst_no_done", 32'(done_cnt), 32'd0);
    check("arst_no_busy", 32'(busy_cnt), 32'd0);
    do_start(1'b0, 4'b1010, 4'b0101);
    wait_done("post_rst", 1'b0);
    idle_check("post_rst");

    // Random operands
    for (int i = 0; i < 6; i++) begin
      do_start(1'($urandom), W'($urandom), W'($urandom));
      wait_done("rand", 1'b0);
      idle_check("rand");
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor_4.md
Name: serial_subtractor_4

Overview:
- Bit-serial subtractor. It is the inverse operation of the team's 4-bit adder.
- It takes an adder result {cout, s} and one operand b, and recovers the other operand: a = {cout,s} − b.
- It processes one bit per clock, LSB first, with a registered borrow.
- It is used in self-checking datapaths and on low-area arithmetic paths. A start/busy/done handshake connects it to a controlling FSM.

Parameters:
- WIDTH, 4, operand width. The minuend is WIDTH+1 bits ({cout,s}) and the subtrahend is WIDTH bits, zero-extended.

Ports:
- clk  input  1  clock; rising-edge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled only in IDLE or DONE
- s  input  WIDTH  low bits of the minuend; captured on accepted start
- cout  input  1  MSB of the minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when the result is valid
- d  output  WIDTH  difference, low WIDTH bits (two's complement if negative)
- borrow  output  1  final borrow: {cout,s} < b
- ovf  output  1  nonnegative result ≥ 2^WIDTH (result bit WIDTH set and no borrow)

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, d=0, borrow=0, ovf=0; all internal shift registers, the borrow flip-flop and the counter are cleared. This overrides everything, including mid-RUN. No result is produced for an aborted operation.
- FSM states are IDLE, RUN and DONE.
- IDLE: start=1 at a rising edge (E0) does the following:
  - M ← {cout,s}, B ← {0,b}, br ← 0, cnt ← 0, R ← 0.
  - Next state is RUN and busy=1.
- RUN: each edge performs one bit step.
  - bit = M[0]^B[0]^br
  - br ← (~M[0]&B[0]) | (~(M[0]^B[0])&br)
  - R ← {bit, R[WIDTH:1]}; M and B shift right by 1; cnt ← cnt+1
  - WIDTH+1 steps are taken, on edges E1..E(WIDTH+1).
  - On the edge performing the last step (cnt==WIDTH before the edge), the next state is DONE.
- DONE, entered at E(WIDTH+1):
  - done=1 and busy=0 for exactly that one cycle.
  - d=R[WIDTH-1:0], borrow=br, ovf=R[WIDTH]&~br, all registered so they are valid together with done.
- Latency: done rises WIDTH+1 cycles after the accepting edge, i.e. 5 cycles for WIDTH=4.
- DONE→IDLE on the next edge if start=0. d, borrow and ovf hold their values until the next accepted start.
- start=1 while in DONE is accepted: the block goes directly to RUN (back-to-back operation). The previous d, borrow and ovf hold until the new DONE.
- start during RUN is ignored. It has no effect on the operands or the count.
- A start held high for several cycles causes a new operation at each IDLE/DONE opportunity. A single start held high continuously therefore gives repeated operations every WIDTH+2 cycles.
- Inputs s, cout and b are don't-care except at the accepting edge.
- Arithmetic is modulo 2^(WIDTH+1). When borrow=1, d is the low WIDTH bits of the two's-complement result.

Test Plan:
- Valid-sum inversion, part 1: cout=1, s=1110, b=1111, one start pulse.
  - Required: busy high 5 cycles, then done pulse.
  - Required values: d=1111, borrow=0, ovf=0.
- Valid-sum inversion, part 2: cout=0, s=0000, b=0000.
  - Required: d=0000, borrow=0, ovf=0 at done, 5 cycles after the accepting edge.
- Negative result: cout=0, s=0001, b=0010 → d=1111, borrow=1, ovf=0.
- Overflow: cout=1, s=0000, b=0000 → d=0000, ovf=1, borrow=0.
- Handshake, start during RUN: pulse start again at E2 with different operands.
  - Required: ignored; done at E5 with the first operands' result.
- Handshake, back-to-back: start=1 in the DONE cycle with cout=0, s=0111, b=0011.
  - Required: busy next cycle; second done WIDTH+1 cycles later with d=0100.
- Reset mid-operation: deassert rst_n asynchronously at E3 of a run, then release.
  - Required: busy, done, d, borrow and ovf all 0 immediately; state IDLE; no done pulse follows; a new start then completes normally.
